unsigned_lincomb_seq_v: RTL and testbench
=========================================

// Module: unsigned_lincomb_seq_v
// PURPOSE
//  Sequential, parametrised successor of the fixed 7A-3B+6C calculator: computes
//  F = KA*A - KB*B + KC*C on unsigned operands with runtime-free constant coefficients.
//  Uses a bit-serial shift-add datapath (one operand bit per cycle) under a valid/ready
//  handshake, and flags negative results and output-width overflow instead of wrapping silently.
// PARAMETERS
//  W   4  operand width (i_au, i_bu, i_cu)
//  CW  3  coefficient width; KA, KB, KC must each be < 2**CW
//  KA  7  coefficient on A (added)
//  KB  3  coefficient on B (subtracted)
//  KC  6  coefficient on C (added)
//  OW  8  result width; must be <= IW. IW = W+CW+2 (localparam, signed accumulator width)
// PORTS
//  i_clk    in   1   clock, all state on rising edge
//  i_rst    in   1   synchronous reset, active-high
//  i_valid  in   1   operands valid
//  o_ready  out  1   block can accept operands
//  i_au     in   W   operand A, unsigned
//  i_bu     in   W   operand B, unsigned
//  i_cu     in   W   operand C, unsigned
//  o_valid  out  1   result valid
//  i_ready  in   1   consumer accepts result
//  o_fu     out  OW  result, low OW bits of the exact two's-complement F
//  o_neg    out  1   F < 0
//  o_ovf    out  1   F >= 2**OW (F not representable unsigned in OW bits, F >= 0)
// BEHAVIOUR
//  - Reset: state IDLE; o_valid=0, o_fu=0, o_neg=0, o_ovf=0; operand regs, acc, bit count = 0.
//    o_ready is 0 while i_rst is high, 1 in IDLE otherwise. Reset wins over every other event.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//  - IDLE: o_ready=1. On edge with i_valid&o_ready: latch A,B,C; acc=0; cnt=0; -> BUSY.
//  - BUSY (exactly W cycles, cnt 0..W-1): o_ready=0, o_valid=0, input handshake ignored.
//    Each edge: acc += (A[cnt]?KA<<cnt:0) - (B[cnt]?KB<<cnt:0) + (C[cnt]?KC<<cnt:0),
//    acc signed IW bits (never overflows by construction); cnt++. At cnt==W-1 -> DONE and
//    register o_fu=acc[OW-1:0], o_neg=acc[IW-1], o_ovf=!acc[IW-1] & (acc >= 2**OW).
//  - Latency: acceptance at edge T -> o_valid=1 after edge T+W. Throughput 1 per W+2 cycles min.
//  - DONE: o_valid=1; o_fu/o_neg/o_ovf held stable until i_ready. Edge with i_ready -> IDLE,
//    o_valid=0 (o_fu/flags keep last value). i_valid in DONE ignored (o_ready=0).
//  - Reset asserted in BUSY or DONE: computation/result discarded, no o_valid pulse.
//  - Negative F: o_fu = F mod 2**OW (two's complement), o_neg=1, o_ovf=0.
//  - Defaults reproduce 7A-3B+6C in 8 bits, identical wrap to the combinational version.
// TESTING
//  1 Defaults, A=15,B=0,C=15 -> after 4 cycles o_valid=1, o_fu=0xC3 (195), neg=0, ovf=0.
//  2 Defaults, A=0,B=15,C=0 -> o_fu=0xD3 (-45 mod 256), o_neg=1, o_ovf=0.
//  3 Backpressure: i_ready=0 for 5 cycles in DONE -> o_valid, o_fu stable; then 1-cycle i_ready
//    -> IDLE, o_ready=1 next cycle; i_valid pulses during BUSY/DONE produce no extra result.
//  4 Reset at BUSY cycle 2 with A=5,B=1,C=2 -> next cycle IDLE, o_valid=0, o_fu=0; new
//    request A=1,B=1,C=1 then yields o_fu=10.
//  5 W=8,CW=3,OW=8: A=255,B=0,C=255 -> F=3315, o_fu=0xF3, o_ovf=1, o_neg=0.
//  6 Defaults exhaustive 4096 triples, random i_valid/i_ready -> o_fu/o_neg/o_ovf match
//    behavioural model; every accepted request yields exactly one result, in order.

Source files
------------

// File: rtl/unsigned_lincomb_seq_v.sv
`default_nettype none
// ============================================================================
//  Module   : unsigned_lincomb_seq_v
//  Purpose  : Bit-serial, handshaked linear combination
//             F = KA*A - KB*B + KC*C over unsigned operands. The result is
//             reported with a negative flag and an output-overflow flag
//             instead of wrapping silently.
//  Revision : 1.0  initial release
// ============================================================================
module unsigned_lincomb_seq_v #(
    parameter int W  = 4,   // operand width
    parameter int CW = 3,   // coefficient width
    parameter int KA = 7,   // coefficient on A (added)
    parameter int KB = 3,   // coefficient on B (subtracted)
    parameter int KC = 6,   // coefficient on C (added)
    parameter int OW = 8    // result width, must not exceed IW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [W-1:0]  i_au,
    input  logic [W-1:0]  i_bu,
    input  logic [W-1:0]  i_cu,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [OW-1:0] o_fu,
    output logic          o_neg,
    output logic          o_ovf
);

    // Two bits of headroom over W+CW keep the signed sum of the two added
    // terms from ever overflowing the accumulator.
    localparam int IW   = W + CW + 2;
    localparam int CNTW = (W > 1) ? $clog2(W) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Coefficients first truncated to CW bits, then widened to the accumulator.
    localparam logic [CW-1:0] c_ka_n = CW'(KA);
    localparam logic [CW-1:0] c_kb_n = CW'(KB);
    localparam logic [CW-1:0] c_kc_n = CW'(KC);
    localparam logic [IW-1:0] c_ka   = IW'(c_ka_n);
    localparam logic [IW-1:0] c_kb   = IW'(c_kb_n);
    localparam logic [IW-1:0] c_kc   = IW'(c_kc_n);
    // 2**OW, one bit wider than the accumulator so OW == IW is still legal.
    localparam logic [IW:0]   c_ovf_lim = (IW+1)'(1) << OW;
    localparam logic [CNTW-1:0] c_last  = CNTW'(W - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_c;
    logic [IW-1:0]   r_acc;
    logic [CNTW-1:0] r_cnt;
    logic [OW-1:0]   r_fu;
    logic            r_neg;
    logic            r_ovf;

    logic            w_accept;
    logic            w_last;
    logic [IW-1:0]   w_ta;
    logic [IW-1:0]   w_tb;
    logic [IW-1:0]   w_tc;
    logic [IW-1:0]   w_acc_next;
    logic            w_neg_next;
    logic            w_ovf_next;

    // Partial products for the current bit position and the next accumulator.
    always_comb begin
        w_ta       = r_a[r_cnt] ? (c_ka << r_cnt) : '0;
        w_tb       = r_b[r_cnt] ? (c_kb << r_cnt) : '0;
        w_tc       = r_c[r_cnt] ? (c_kc << r_cnt) : '0;
        w_acc_next = r_acc + w_ta - w_tb + w_tc;
        w_neg_next = w_acc_next[IW-1];
        w_ovf_next = !w_neg_next && ({1'b0, w_acc_next} >= c_ovf_lim);
        w_last     = (r_cnt == c_last);
    end

    // State register; reset overrides any in-flight computation or result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and input-side handshake.
    always_comb begin
        w_next_state = r_state;
        o_ready      = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_ready  = !i_rst;
                w_accept = i_valid && !i_rst;
                if (w_accept) begin
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand capture, serial accumulation and result registering.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_fu  <= '0;
            r_neg <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a   <= i_au;
                        r_b   <= i_bu;
                        r_c   <= i_cu;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                S_BUSY: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_fu  <= w_acc_next[OW-1:0];
                        r_neg <= w_neg_next;
                        r_ovf <= w_ovf_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_valid = (r_state == S_DONE);
    assign o_fu    = r_fu;
    assign o_neg   = r_neg;
    assign o_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_unsigned_lincomb_seq_v.sv
`default_nettype none
// ============================================================================
//  Module   : tb_unsigned_lincomb_seq_v
//  Purpose  : Scoreboard bench for unsigned_lincomb_seq_v (default and W=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_unsigned_lincomb_seq_v;

    typedef struct {
        logic [7:0] fu;
        logic       neg;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] au, bu, cu;
    logic       out_valid;
    logic       in_ready;
    logic [7:0] fu;
    logic       neg, ovf;

    logic       v8, rdy8, ov8, ir8;
    logic [7:0] a8, b8, c8, fu8;
    logic       neg8, ovf8;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    exp_t q8[$];
    exp_t mon_e, mon8_e;
    logic rdy_rand = 1'b0;
    logic rdy_val  = 1'b1;

    unsigned_lincomb_seq_v u_dut (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(out_ready),
        .i_au(au), .i_bu(bu), .i_cu(cu), .o_valid(out_valid), .i_ready(in_ready),
        .o_fu(fu), .o_neg(neg), .o_ovf(ovf)
    );

    unsigned_lincomb_seq_v #(.W(8), .CW(3), .KA(7), .KB(3), .KC(6), .OW(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(rdy8),
        .i_au(a8), .i_bu(b8), .i_cu(c8), .o_valid(ov8), .i_ready(ir8),
        .o_fu(fu8), .o_neg(neg8), .o_ovf(ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b, input int c);
        exp_t r;
        int   f;
        f     = 7*a - 3*b + 6*c;
        r.fu  = 8'(f);
        r.neg = (f < 0);
        r.ovf = (f >= 256);
        return r;
    endfunction

    // Consumer ready: random or forced level, driven clear of the stimulus slot.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            in_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
        end
    end

    // Result monitor for the default instance.
    always @(negedge clk) begin
        if (!rst && out_valid && in_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got fu=%0d expected no result", fu);
            end else begin
                mon_e = sb.pop_front();
                chk("res_fu",  32'(fu),  32'(mon_e.fu));
                chk("res_neg", 32'(neg), 32'(mon_e.neg));
                chk("res_ovf", 32'(ovf), 32'(mon_e.ovf));
            end
        end
    end

    // Result monitor for the W=8 instance.
    always @(negedge clk) begin
        if (!rst && ov8 && ir8) begin
            if (q8.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result_w8: got fu=%0d expected no result", fu8);
            end else begin
                mon8_e = q8.pop_front();
                chk("w8_fu",  32'(fu8),  32'(mon8_e.fu));
                chk("w8_neg", 32'(neg8), 32'(mon8_e.neg));
                chk("w8_ovf", 32'(ovf8), 32'(mon8_e.ovf));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input int a, input int b, input int c, input exp_t e);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        au = 4'(a); bu = 4'(b); cu = 4'(c);
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (out_ready) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (ok) begin
            @(posedge clk);
            sb.push_back(e);
            #1;
            in_valid = 1'b0;
        end else begin
            total++;
            bad++;
            $display("FAIL send_timeout: got ready=0 expected ready=1");
            in_valid = 1'b0;
        end
    endtask

    // Counts edges from acceptance until o_valid is seen; returns at a negedge.
    task automatic wait_valid(output int lat);
        bit ok;
        ok  = 1'b0;
        lat = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
            else begin @(posedge clk); #1; lat++; end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 2000 && (sb.size() != 0 || q8.size() != 0); k++)
            @(posedge clk);
        #1;
    endtask

    int va[9] = '{15,  0, 15, 0,  3,   2,   0,   1,  0};
    int vb[9] = '{ 0, 15, 15, 0, 15,   5,   1,   1,  0};
    int vc[9] = '{15,  0, 15, 0,  0,   0,   0,   1, 15};
    int ef[9] = '{195, 211, 150, 0, 232, 255, 253, 10, 90};
    int en[9] = '{ 0,  1,  0, 0,  1,   1,   1,   0,  0};

    initial begin
        int lat;
        bit ok;
        exp_t e;
        rst = 1'b1; in_valid = 1'b0; au = '0; bu = '0; cu = '0; in_ready = 1'b0;
        v8 = 1'b0; a8 = '0; b8 = '0; c8 = '0; ir8 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_fu",    32'(fu),        32'd0);
        chk("rst_neg",   32'(neg),       32'd0);
        chk("rst_ovf",   32'(ovf),       32'd0);
        chk("rst_ready", 32'(out_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(out_ready), 32'd1);
        @(posedge clk); #1;

        // Latency of the first request, consumer always ready.
        send(15, 0, 15, exp_t'{8'd195, 1'b0, 1'b0});
        wait_valid(lat);
        chk("latency", 32'(lat), 32'd4);
        @(posedge clk); #1;

        // Directed vectors, hand-computed expectations, random consumer.
        rdy_rand = 1'b1;
        for (int i = 0; i < 9; i++) begin
            e.fu = 8'(ef[i]); e.neg = en[i][0]; e.ovf = 1'b0;
            send(va[i], vb[i], vc[i], e);
        end
        drain();

        // Backpressure with stray i_valid during BUSY and DONE.
        rdy_rand = 1'b0; rdy_val = 1'b0;
        @(posedge clk); #1;
        send(15, 0, 15, exp_t'{8'd195, 1'b0, 1'b0});
        in_valid = 1'b1; au = 4'd1; bu = 4'd1; cu = 4'd1;
        wait_valid(lat);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_fu",    32'(fu),        32'd195);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rdy_val  = 1'b1;
        @(posedge clk); #1;
        rdy_val  = 1'b0;
        @(negedge clk);
        chk("bp_ready_after", 32'(out_ready), 32'd1);
        chk("bp_valid_after", 32'(out_valid), 32'd0);
        rdy_val = 1'b1;
        repeat (12) @(posedge clk);
        #1;

        // Wide instance: F = 3315 overflows 8 bits.
        ok = 1'b0;
        v8 = 1'b1; a8 = 8'd255; b8 = 8'd0; c8 = 8'd255;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (rdy8) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("w8_accept", 32'(ok), 32'd1);
        @(posedge clk);
        if (ok) q8.push_back(exp_t'{8'hF3, 1'b0, 1'b1});
        #1;
        v8 = 1'b0;
        drain();

        // Reset in the middle of a computation discards it.
        in_valid = 1'b1; au = 4'd5; bu = 4'd1; cu = 4'd2;
        @(negedge clk);
        chk("rs_ready", 32'(out_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rs_valid", 32'(out_valid), 32'd0);
        chk("rs_fu",    32'(fu),        32'd0);
        chk("rs_ready_in_rst", 32'(out_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rs_ready_after", 32'(out_ready), 32'd1);
        @(posedge clk); #1;
        send(1, 1, 1, exp_t'{8'd10, 1'b0, 1'b0});
        drain();

        // All operand triples against the reference model, random handshake.
        rdy_rand = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            if ($urandom_range(0, 1) != 0) begin @(posedge clk); #1; end
            send((i >> 8) & 15, (i >> 4) & 15, i & 15, model((i >> 8) & 15, (i >> 4) & 15, i & 15));
        end
        drain();

        total++;
        if (sb.size() != 0 || q8.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size() + q8.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
